// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load-store unit: access-size codes, FSM states
// and the lane helpers used to build byte enables and store data.
package riscv_lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_t;

    // Misaligned halves/words are truncated onto their natural lanes.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
        case (size)
            LDST_B, LDST_BU: byte_en = 4'b0001 << off;
            LDST_H, LDST_HU: byte_en = 4'b0011 << {off[1], 1'b0};
            LDST_W:          byte_en = 4'b1111;
            default:         byte_en = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] size, input logic [31:0] wd);
        case (size)
            LDST_B, LDST_BU: store_data = {4{wd[7:0]}};
            LDST_H, LDST_HU: store_data = {2{wd[15:0]}};
            default:         store_data = wd;
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_load_extract.sv
// Picks the addressed byte/half out of a memory word and sign- or
// zero-extends it according to the load size.
module lsu_load_extract
    import riscv_lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [2:0]  size,
    input  logic [1:0]  offset,
    output logic [31:0] rd_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = rd_word[7:0];
            2'd1:    byte_sel = rd_word[15:8];
            2'd2:    byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        half_sel = offset[1] ? rd_word[31:16] : rd_word[15:0];

        case (size)
            LDST_B:  rd_data = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: rd_data = {24'd0, byte_sel};
            LDST_H:  rd_data = {{16{half_sel[15]}}, half_sel};
            LDST_HU: rd_data = {16'd0, half_sel};
            LDST_W:  rd_data = rd_word;
            default: rd_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load-store unit: turns one core access into a word-aligned memory transaction,
// stalls the core until ready (or watchdog timeout). Optional LSU_MISALIGN_EN.
//
// state | meaning
// IDLE  | no access outstanding; a core request is issued and stalled this cycle
// WAIT  | access issued, holding mem_req_o until mem_ready_i or watchdog expiry
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        bus_err_o,
`ifdef LSU_MISALIGN_EN
    output logic        misalign_o,
`endif
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);

    lsu_state_t     state;
    logic [CW-1:0]  wait_cnt;
    logic           held_we;
    logic [2:0]     held_size;
    logic [31:0]    held_addr;
    logic [31:0]    held_wd;

    logic           busy;
    logic           misaligned;
    logic           accept;
    logic           timeout;
    logic           cur_we;
    logic [2:0]     cur_size;
    logic [31:0]    cur_addr;
    logic [31:0]    cur_wd;
    logic [31:0]    load_data;

    assign busy = (state == WAIT);

`ifdef LSU_MISALIGN_EN
    assign misaligned = (((core_size_i == LDST_H) || (core_size_i == LDST_HU)) && core_addr_i[0]) ||
                        ((core_size_i == LDST_W) && (core_addr_i[1:0] != 2'b00));
    assign misalign_o = ~rst_i & ~busy & core_req_i & misaligned;
`else
    assign misaligned = 1'b0;
`endif

    assign accept  = ~rst_i & ~busy & core_req_i & ~misaligned;
    // Ready wins over the watchdog if both land in the same cycle.
    assign timeout = busy & ~mem_ready_i & (TIMEOUT_CYCLES != 0) & (wait_cnt == TIMEOUT_VAL);

    // The issue cycle uses the live request; WAIT uses the captured copy so an
    // illegally dropped request still completes cleanly.
    assign cur_we   = busy ? held_we   : core_we_i;
    assign cur_size = busy ? held_size : core_size_i;
    assign cur_addr = busy ? held_addr : core_addr_i;
    assign cur_wd   = busy ? held_wd   : core_wd_i;

    assign mem_req_o    = accept | busy;
    assign mem_we_o     = mem_req_o & cur_we;
    assign mem_addr_o   = {cur_addr[31:2], 2'b00};
    assign mem_be_o     = byte_en(cur_size, cur_addr[1:0]);
    assign mem_wd_o     = store_data(cur_size, cur_wd);
    assign core_stall_o = accept | (busy & ~mem_ready_i & ~timeout);
    assign bus_err_o    = timeout;

    lsu_load_extract u_extract (
        .rd_word (mem_rd_i),
        .size    (held_size),
        .offset  (held_addr[1:0]),
        .rd_data (load_data)
    );

    assign core_rd_o = timeout ? 32'd0 : load_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            held_we   <= 1'b0;
            held_size <= 3'd0;
            held_addr <= 32'd0;
            held_wd   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= WAIT;
                        wait_cnt  <= '0;
                        held_we   <= core_we_i;
                        held_size <= core_size_i;
                        held_addr <= core_addr_i;
                        held_wd   <= core_wd_i;
                    end
                end
                WAIT: begin
                    if (mem_ready_i || timeout) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (TIMEOUT_CYCLES > 0) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load-store unit: the responder for the core's data-memory request port (req/we/size/addr/wd, rd_data, stall).
- Accepts one core access at a time and converts it into a word-aligned external memory transaction with byte enables and a ready handshake.
- Holds the core stalled until the transaction completes, then returns sign- or zero-extended load data.
- Sits between the core and the data memory / peripheral interconnect.

Parameters:
- TIMEOUT_CYCLES, 16: maximum WAIT cycles before a bus error is flagged; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- core_req_i  in  1  core requests a memory access
- core_we_i  in  1  1 = store, 0 = load
- core_size_i  in  3  funct3 encoding: 0 B, 1 H, 2 W, 4 BU, 5 HU
- core_addr_i  in  32  byte address
- core_wd_i  in  32  store data, right-aligned
- core_rd_o  out  32  extended load data
- core_stall_o  out  1  hold core (PC, register-file write)
- bus_err_o  out  1  one-cycle pulse on watchdog timeout
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  {core_addr_i[31:2], 2'b00}
- mem_wd_o  out  32  lane-replicated store data
- mem_rd_i  in  32  memory read word
- mem_ready_i  in  1  transaction complete

Behaviour:
- FSM states: IDLE, WAIT. Reset: state IDLE, timeout counter 0, core_stall_o 0, bus_err_o 0, mem_req_o 0, mem_we_o 0.
- IDLE:
  - core_req_i=1 → mem_req_o=1, mem_we_o=core_we_i, core_stall_o=1, next state WAIT.
  - mem_ready_i is ignored in IDLE, so every access has a minimum latency of 1 stall cycle.
- WAIT:
  - mem_req_o held at 1; core holds its request stable because it is stalled.
  - mem_ready_i=1 → core_stall_o=0 in the same cycle (combinational); core_rd_o is valid that cycle; next state IDLE.
  - mem_ready_i=0 → core_stall_o=1; counter increments.
- Watchdog: when the counter reaches TIMEOUT_CYCLES, bus_err_o pulses for 1 cycle, core_stall_o=0, core_rd_o=0, next state IDLE. Counter clears on every exit from WAIT.
- Back-to-back accesses: a new core_req_i in the cycle after completion is handled from IDLE, with no bubble beyond the mandatory stall cycle.
- Byte enables:
  - B/BU: 4'b0001 << addr[1:0]
  - H/HU: 4'b0011 << {addr[1], 1'b0}
  - W: 4'b1111
  - any other size: 4'b0000 and the access still completes.
- mem_wd_o:
  - B: {4{wd[7:0]}}
  - H: {2{wd[15:0]}}
  - W: wd
- Load extract:
  - Select byte or half from mem_rd_i by addr[1:0].
  - B/H sign-extend; BU/HU zero-extend; W passes through unchanged.
  - Pure combinational from the held address.
- mem_be_o and mem_wd_o are don't-care when mem_we_o=0, but are driven deterministically.
- Reset asserted mid-WAIT: immediately IDLE, mem_req_o=0, stall drops, no error pulse.
- core_req_i dropping while in WAIT is illegal core behaviour. The LSU still completes the transaction.

Optional Feature:
- Macro LSU_MISALIGN_EN.
- Defined: H/HU with addr[0]=1, or W with addr[1:0]!=0, does not issue mem_req_o. Instead:
  - extra output misalign_o pulses for 1 cycle (port exists only under the macro);
  - core_stall_o=0 that cycle; FSM stays IDLE.
- Undefined: misaligned addresses are silently truncated via the byte-enable shift rules above.

Decomposition:
- riscv_lsu_pkg:
  - size constants LDST_B=3'd0, LDST_H=3'd1, LDST_W=3'd2, LDST_BU=3'd4, LDST_HU=3'd5;
  - FSM state enum lsu_state_t {IDLE, WAIT}.
- One combinational sub-module, lsu_load_extract (mem_rd_i, size, offset → core_rd_o). Shared by RTL and the bench reference model.

Test Plan:
- LW addr 0x100, mem_ready_i 2 cycles after request, mem_rd_i 0xDEADBEEF → stall high 2 cycles, mem_be_o 4'b1111, core_rd_o 0xDEADBEEF in the release cycle.
- LB addr 0x103, mem_rd_i 0x80FF0011 → be 4'b1000, core_rd_o 0xFFFFFF80; same access as LBU → 0x00000080.
- SH addr 0x202, wd 0x1234ABCD, ready next cycle → mem_we_o=1, be 4'b1100, mem_wd_o 0xABCDABCD, mem_addr_o 0x200, stall exactly 1 cycle.
- Load with mem_ready_i never asserted, TIMEOUT_CYCLES=16 → bus_err_o single pulse after 16 WAIT cycles, stall released, state IDLE.
- rst_i asserted during WAIT → mem_req_o and core_stall_o go to 0 asynchronously; a following LW runs normally.
- LSU_MISALIGN_EN defined, LW addr 0x101 → no mem_req_o, misalign_o pulse, no stall; undefined → be 4'b1111, addr 0x100.
